e_mdu: RTL and testbench

//   Execute-stage multiply/divide unit owning the HI/LO registers.

---
 rtl/e_mdu.sv | 195 +++++++++++++++++++
 tb/tb_e_mdu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu -- execute-stage multiply/divide unit that owns the HI/LO registers.
//
// MULT/MULTU/DIV/DIVU run as multi-cycle operations. The full 64-bit result
// is computed when the operation is accepted and parked in hi_tmp/lo_tmp.
// It is committed to HI/LO on the last busy edge, so the new values are
// readable in the first cycle that busy is low. MTHI/MTLO write HI/LO
// directly while the unit is idle.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   start     in   E-stage instruction is MULT/MULTU/DIV/DIVU (one-cycle pulse)
//   mdu_op    in   [3:0] 0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,
//                  7 MTHI,8 MTLO; any other code behaves as NONE
//   rs        in   [31:0] dividend / multiplicand / MTHI-MTLO data
//   rt        in   [31:0] divisor / multiplier
//   busy      out  operation in flight (registered)
//   hilo_out  out  [31:0] HI for MFHI, LO for MFLO, otherwise 0
//   hi, lo    out  [31:0] current HI/LO registers (debug visibility)
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hilo_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        hi_tmp_q, hi_tmp_d;
  logic [31:0]        lo_tmp_q, lo_tmp_d;
  logic               wr_q, wr_d;      // commit enable; low for divide-by-zero
  logic               is_arith;

  // Full 64-bit signed product of two sign-extended operands.
  function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    a_ext = {{32{a[31]}}, a};
    b_ext = {{32{b[31]}}, b};
    return a_ext * b_ext;
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Signed divide on magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. |0x80000000| is still 0x80000000
  // as an unsigned magnitude, so 0x80000000 / -1 yields 0x80000000, rem 0.
  // Returns {remainder, quotient}.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic [31:0] mag_a, mag_b, q_mag, r_mag, quo, rem;
    if (b == 32'sd0) return 64'd0;
    mag_a = a[31] ? (~a + 32'd1) : a;
    mag_b = b[31] ? (~b + 32'd1) : b;
    q_mag = mag_a / mag_b;
    r_mag = mag_a % mag_b;
    quo   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    rem   = a[31] ? (~r_mag + 32'd1) : r_mag;
    return {rem, quo};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  assign is_arith = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    wr_d     = wr_q;

    case (state_q)
      IDLE: begin
        // An accepted start takes priority over MTHI/MTLO in the same cycle.
        if (start && is_arith) begin
          state_d = BUSY;
          wr_d    = 1'b1;
          case (mdu_op)
            OP_MULT: begin
              {hi_tmp_d, lo_tmp_d} = mul_signed(rs, rt);
              cnt_d = CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
              {hi_tmp_d, lo_tmp_d} = mul_unsigned(rs, rt);
              cnt_d = CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
              {hi_tmp_d, lo_tmp_d} = div_signed(rs, rt);
              cnt_d = CNT_W'(DIV_CYCLES);
              wr_d  = (rt != 32'd0);
            end
            default: begin
              {hi_tmp_d, lo_tmp_d} = div_unsigned(rs, rt);
              cnt_d = CNT_W'(DIV_CYCLES);
              wr_d  = (rt != 32'd0);
            end
          endcase
        end else if (mdu_op == OP_MTHI) begin
          hi_d = rs;
        end else if (mdu_op == OP_MTLO) begin
          lo_d = rs;
        end
      end
      BUSY: begin
        // start and MT* are deliberately ignored here: no restart, no writes.
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (wr_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      wr_q     <= wr_d;
    end
  end

  always_comb begin
    hilo_out = 32'd0;
    if (mdu_op == OP_MFHI)      hilo_out = hi_q;
    else if (mdu_op == OP_MFLO) hilo_out = lo_q;
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu: directed steps followed by randomized operations,
// each checked against a plain-arithmetic reference model of HI/LO.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdu_op   (mdu_op),
    .rs       (rs),
    .rt       (rt),
    .busy     (busy),
    .hilo_out (hilo_out),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: architectural effect of one MDU instruction on HI/LO.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr, sp;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin sp = sa * sb; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
      4'd2: begin
        up = longint'(a) * longint'(b);
        exp_hi = up[63:32]; exp_lo = up[31:0];
      end
      4'd3: if (b != 0) begin
        sq = sa / sb; sr = sa % sb;
        exp_lo = sq[31:0]; exp_hi = sr[31:0];
      end
      4'd4: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      4'd7: exp_hi = a;
      4'd8: exp_lo = a;
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    mdu_op = 4'd5;
    #1;
    chk({tag, "_mfhi"}, hilo_out, exp_hi);
    mdu_op = 4'd6;
    #1;
    chk({tag, "_mflo"}, hilo_out, exp_lo);
    mdu_op = 4'd0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string tag);
    logic [31:0] old_hi;
    int cycles;
    old_hi = exp_hi;
    model(op, a, b);
    start  = 1'b1;
    mdu_op = op;
    rs     = a;
    rt     = b;
    step();
    start  = 1'b0;
    mdu_op = 4'd0;
    chk({tag, "_early_hi"}, hi, old_hi);
    cycles = 0;
    while (busy === 1'b1 && cycles < n + 4) begin
      cycles++;
      step();
    end
    chk({tag, "_busy_cycles"}, 32'(cycles), 32'(n));
    check_regs(tag);
  endtask

  task automatic write_mt(input logic [3:0] op, input logic [31:0] a);
    model(op, a, 32'd0);
    mdu_op = op;
    rs     = a;
    step();
    mdu_op = 4'd0;
  endtask

  initial begin
    int cycles;
    int r;
    logic [31:0] a;
    logic [31:0] b;
    vectors     = 0;
    miscompares = 0;
    exp_hi      = 32'd0;
    exp_lo      = 32'd0;
    reset  = 1'b0;
    start  = 1'b0;
    mdu_op = 4'd0;
    rs     = 32'd0;
    rt     = 32'd0;

    // Reset state
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    for (int op = 0; op < 16; op++) begin
      mdu_op = 4'(op);
      #1;
      chk("rst_hilo_out", hilo_out, 32'd0);
    end
    mdu_op = 4'd0;

    // Directed arithmetic
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 5, "mult_neg1x2");
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 5, "multu_maxx2");
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, "div_m7d2");
    run_op(4'd4, 32'd7, 32'd2, 10, "divu_7d2");
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");

    // Divide by zero leaves HI/LO untouched after a full busy period
    write_mt(4'd7, 32'h11);
    write_mt(4'd8, 32'h22);
    run_op(4'd4, 32'd5, 32'd0, 10, "divu_by0");
    run_op(4'd3, 32'd5, 32'd0, 10, "div_by0");

    // MTHI visible next cycle through MFHI
    write_mt(4'd7, 32'h1234);
    mdu_op = 4'd5;
    #1;
    chk("mthi_mfhi", hilo_out, 32'h1234);
    mdu_op = 4'd0;

    // MTLO and start while busy are ignored; busy length unchanged
    model(4'd1, 32'd3, 32'd5);
    start = 1'b1; mdu_op = 4'd1; rs = 32'd3; rt = 32'd5;
    step();
    start = 1'b0; mdu_op = 4'd0;
    step();
    mdu_op = 4'd5;
    #1;
    chk("busy_mfhi_old", hilo_out, 32'h1234);
    mdu_op = 4'd8; rs = 32'hDEAD_BEEF;
    step();
    start = 1'b1; mdu_op = 4'd3; rs = 32'd100; rt = 32'd7;
    step();
    start = 1'b0; mdu_op = 4'd0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 10) begin
      cycles++;
      step();
    end
    chk("ignore_busy_rest", 32'(cycles), 32'd2);
    check_regs("ignore_busy");

    // Async reset in the 4th busy cycle of a DIV aborts without commit
    start = 1'b1; mdu_op = 4'd4; rs = 32'd99; rt = 32'd4;
    step();
    start = 1'b0; mdu_op = 4'd0;
    repeat (3) step();
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    #2;
    reset = 1'b1;
    repeat (15) step();
    chk("abort_no_commit_busy", {31'd0, busy}, 32'd0);
    check_regs("abort_no_commit");

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      case (r)
        0: run_op(4'd1, a, b, 5, "rnd_mult");
        1: run_op(4'd2, a, b, 5, "rnd_multu");
        2: run_op(4'd3, a, b, 10, "rnd_div");
        3: run_op(4'd4, a, b, 10, "rnd_divu");
        4: begin write_mt(4'd7, a); check_regs("rnd_mthi"); end
        default: begin write_mt(4'd8, a); check_regs("rnd_mtlo"); end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
